// File: rtl/adc_capture_pkg.sv
// Shared types and constants for the ADC capture buffer.
//   cap_state_t : capture FSM state encoding (also driven onto the debug/LED port)
//   TRIG_*      : trig_mode encodings
package adc_capture_pkg;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PRE       = 3'd1,
      WAIT_TRIG = 3'd2,
      POST      = 3'd3,
      READ      = 3'd4
   } cap_state_t;

   localparam logic [1:0] TRIG_IMM  = 2'd0;
   localparam logic [1:0] TRIG_RISE = 2'd1;
   localparam logic [1:0] TRIG_EXT  = 2'd2;
   localparam logic [1:0] TRIG_FALL = 2'd3;

endpackage

// File: rtl/adc_sample_ram.sv
// Simple dual-port capture RAM, single clock, synchronous write,
// registered read (1-cycle latency). Written so it maps onto block RAM.
//   clock        : sample clock
//   we/waddr/wdata : write port
//   re/raddr     : read request; rdata is valid on the following cycle and
//                  holds its value while re is low
//   rdata        : read data
module adc_sample_ram
   import adc_capture_pkg::*;
#(
   parameter int WIDTH  = 16,
   parameter int DEPTH  = 1024,
   localparam int ADDR_W = $clog2(DEPTH)
) (
   input  logic              clock,
   input  logic              we,
   input  logic [ADDR_W-1:0] waddr,
   input  logic [WIDTH-1:0]  wdata,
   input  logic              re,
   input  logic [ADDR_W-1:0] raddr,
   output logic [WIDTH-1:0]  rdata
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [WIDTH-1:0] rdata_q;

   always_ff @(posedge clock) begin
      if (we) mem[waddr] <= wdata;
      if (re) rdata_q <= mem[raddr];
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/adc_capture_buffer.sv
// Triggered circular capture of de-serialised ADC beats with stream replay.
//   clock, reset          : sample clock, synchronous active-high reset
//   din, din_valid        : NUM_CH samples per beat, ch0 in the low bits
//   arm, abort            : start a capture (IDLE only) / return to IDLE
//   trig_mode, threshold,
//   trig_ext              : trigger selection and level
//   rd_data/rd_valid/
//   rd_ready/rd_last      : replay stream, oldest beat first
//   trig_addr             : RAM address of the trigger beat
//   state, done           : debug state, end-of-readout pulse
//
// state     | meaning
// IDLE      | waiting for arm
// PRE       | filling PRE_TRIG pre-trigger beats, trigger ignored
// WAIT_TRIG | circular writes, trigger evaluated per valid beat
// POST      | writing the remainder of the record after the trigger
// READ      | replaying DEPTH beats from the oldest address
module adc_capture_buffer
   import adc_capture_pkg::*;
#(
   parameter int DATA_W   = 8,
   parameter int NUM_CH   = 2,
   parameter int DEPTH    = 1024,
   parameter int PRE_TRIG = 256,
   localparam int ADDR_W  = $clog2(DEPTH)
) (
   input  logic                       clock,
   input  logic                       reset,
   input  logic [NUM_CH*DATA_W-1:0]   din,
   input  logic                       din_valid,
   input  logic                       arm,
   input  logic                       abort,
   input  logic [1:0]                 trig_mode,
   input  logic [DATA_W-1:0]          threshold,
   input  logic                       trig_ext,
   output logic [NUM_CH*DATA_W-1:0]   rd_data,
   output logic                       rd_valid,
   input  logic                       rd_ready,
   output logic                       rd_last,
   output logic [ADDR_W-1:0]          trig_addr,
   output logic [2:0]                 state,
   output logic                       done
);

   localparam int WORD_W   = NUM_CH * DATA_W;
   localparam int CNT_W    = ADDR_W + 1;
   localparam int POST_LEN = DEPTH - PRE_TRIG;
   localparam logic [CNT_W-1:0] CNT_PRE   = CNT_W'(PRE_TRIG);
   localparam logic [CNT_W-1:0] CNT_POST  = CNT_W'(POST_LEN - 1);
   localparam logic [CNT_W-1:0] CNT_DEPTH = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

   cap_state_t          state_q, state_d;
   logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W-1:0]   rd_ptr_q, rd_ptr_d;
   // One down-counter serves PRE, POST (beats left to write) and READ (reads left to issue).
   logic [CNT_W-1:0]    cnt_q, cnt_d;
   logic [DATA_W-1:0]   prev_q, prev_d;
   logic                prev_vld_q, prev_vld_d;
   logic [ADDR_W-1:0]   trig_addr_q, trig_addr_d;
   logic                done_q, done_d;

   // Read pipeline: RAM output stage, output register and skid register.
   logic                ram_vld_q, ram_vld_d;
   logic                ram_last_q, ram_last_d;
   logic                out_vld_q, out_vld_d;
   logic [WORD_W-1:0]   out_data_q, out_data_d;
   logic                out_last_q, out_last_d;
   logic                skid_vld_q, skid_vld_d;
   logic [WORD_W-1:0]   skid_data_q, skid_data_d;
   logic                skid_last_q, skid_last_d;

   logic [DATA_W-1:0]   cur;
   logic [WORD_W-1:0]   ram_rdata;
   logic                we, trig_hit, fire, issue, capturing;
   logic [1:0]          inflight;

   assign cur  = din[DATA_W-1:0];
   assign fire = out_vld_q & rd_ready;
   // Words held in RAM stage + output + skid never exceed two, so a word
   // leaving the RAM always has somewhere to land.
   assign inflight = 2'(ram_vld_q) + 2'(out_vld_q) + 2'(skid_vld_q);
   assign issue    = (state_q == READ) && (cnt_q != '0) && ((inflight - 2'(fire)) < 2'd2);

   always_comb begin
      trig_hit = 1'b0;
      case (trig_mode)
         TRIG_IMM:  trig_hit = 1'b1;
         TRIG_RISE: trig_hit = prev_vld_q && (prev_q < threshold) && (cur >= threshold);
         TRIG_EXT:  trig_hit = trig_ext;
         TRIG_FALL: trig_hit = prev_vld_q && (prev_q >= threshold) && (cur < threshold);
      endcase
   end

   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      cnt_d       = cnt_q;
      prev_d      = prev_q;
      prev_vld_d  = prev_vld_q;
      trig_addr_d = trig_addr_q;
      done_d      = 1'b0;
      we          = 1'b0;
      capturing   = (state_q == PRE) || (state_q == WAIT_TRIG) || (state_q == POST);

      if (capturing && din_valid) begin
         we         = 1'b1;
         wr_ptr_d   = wr_ptr_q + 1'b1;
         prev_d     = cur;
         prev_vld_d = 1'b1;
      end

      case (state_q)
         IDLE: begin
            if (arm) begin
               state_d    = PRE;
               cnt_d      = CNT_PRE;
               prev_vld_d = 1'b0;
            end
         end
         PRE: begin
            if (din_valid) begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CNT_ONE) state_d = WAIT_TRIG;
            end
         end
         WAIT_TRIG: begin
            if (din_valid && trig_hit) begin
               trig_addr_d = wr_ptr_q;
               if (POST_LEN == 1) begin
                  state_d  = READ;
                  cnt_d    = CNT_DEPTH;
                  rd_ptr_d = wr_ptr_d;
               end else begin
                  state_d = POST;
                  cnt_d   = CNT_POST;
               end
            end
         end
         POST: begin
            if (din_valid) begin
               cnt_d = cnt_q - 1'b1;
               if (cnt_q == CNT_ONE) begin
                  // The next write address is the oldest beat of the record.
                  state_d  = READ;
                  cnt_d    = CNT_DEPTH;
                  rd_ptr_d = wr_ptr_d;
               end
            end
         end
         READ: begin
            if (issue) begin
               cnt_d    = cnt_q - 1'b1;
               rd_ptr_d = rd_ptr_q + 1'b1;
            end
            if (fire && out_last_q) begin
               done_d  = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase

      if (abort) begin
         state_d = IDLE;
         done_d  = 1'b0;
      end
   end

   always_comb begin
      ram_vld_d   = issue;
      ram_last_d  = issue && (cnt_q == CNT_ONE);
      out_vld_d   = out_vld_q;
      out_data_d  = out_data_q;
      out_last_d  = out_last_q;
      skid_vld_d  = skid_vld_q;
      skid_data_d = skid_data_q;
      skid_last_d = skid_last_q;

      if (!out_vld_q || fire) begin
         if (skid_vld_q) begin
            out_vld_d   = 1'b1;
            out_data_d  = skid_data_q;
            out_last_d  = skid_last_q;
            skid_vld_d  = ram_vld_q;
            skid_data_d = ram_rdata;
            skid_last_d = ram_last_q;
         end else begin
            out_vld_d = ram_vld_q;
            if (ram_vld_q) begin
               out_data_d = ram_rdata;
               out_last_d = ram_last_q;
            end
         end
      end else if (ram_vld_q) begin
         skid_vld_d  = 1'b1;
         skid_data_d = ram_rdata;
         skid_last_d = ram_last_q;
      end

      if (state_d != READ) begin
         ram_vld_d  = 1'b0;
         out_vld_d  = 1'b0;
         skid_vld_d = 1'b0;
      end
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q     <= IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         cnt_q       <= '0;
         prev_q      <= '0;
         prev_vld_q  <= 1'b0;
         trig_addr_q <= '0;
         done_q      <= 1'b0;
         ram_vld_q   <= 1'b0;
         ram_last_q  <= 1'b0;
         out_vld_q   <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         skid_vld_q  <= 1'b0;
         skid_data_q <= '0;
         skid_last_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         cnt_q       <= cnt_d;
         prev_q      <= prev_d;
         prev_vld_q  <= prev_vld_d;
         trig_addr_q <= trig_addr_d;
         done_q      <= done_d;
         ram_vld_q   <= ram_vld_d;
         ram_last_q  <= ram_last_d;
         out_vld_q   <= out_vld_d;
         out_data_q  <= out_data_d;
         out_last_q  <= out_last_d;
         skid_vld_q  <= skid_vld_d;
         skid_data_q <= skid_data_d;
         skid_last_q <= skid_last_d;
      end
   end

   adc_sample_ram #(
      .WIDTH (WORD_W),
      .DEPTH (DEPTH)
   ) u_ram (
      .clock (clock),
      .we    (we),
      .waddr (wr_ptr_q),
      .wdata (din),
      .re    (issue),
      .raddr (rd_ptr_q),
      .rdata (ram_rdata)
   );

   assign rd_data   = out_data_q;
   assign rd_valid  = out_vld_q;
   assign rd_last   = out_vld_q & out_last_q;
   assign trig_addr = trig_addr_q;
   assign state     = state_q;
   assign done      = done_q;

endmodule
